// File: rtl/gray_pkg.sv
// Shared types, the forward gray sequence, and gray helper functions for the
// gray-code sequence monitor.
package gray_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    FAULT    = 2'd2
  } state_t;

  // Entry i is the gray code of binary i, so the sequence position equals gray2bin.
  localparam logic [0:7][2:0] FWD_SEQ = {
    3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100
  };

  function automatic logic [2:0] gray2bin(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  function automatic logic [2:0] next_gray(input logic [2:0] g);
    logic [2:0] idx;
    idx = gray2bin(g) + 3'd1;
    return FWD_SEQ[idx];
  endfunction

  function automatic logic [2:0] prev_gray(input logic [2:0] g);
    logic [2:0] idx;
    idx = gray2bin(g) - 3'd1;
    return FWD_SEQ[idx];
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational 3-bit gray to binary converter feeding the monitor's Bin register.
module gray_to_bin
  import gray_pkg::*;
(
  input  logic [2:0] gray,
  output logic [2:0] bin
);

  assign bin = gray2bin(gray);

endmodule

// File: rtl/gray_code_monitor.sv
// Tracks a 3-bit gray-coded state stream, counts sequence wraps and flags illegal steps.
// Define GRAY_DIR_DETECT_EN to accept single backward steps and add the Dir output.
module gray_code_monitor
  import gray_pkg::*;
#(
  parameter int LAP_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [2:0]       S,
  input  logic             S_valid,
  input  logic             Clr_err,
  output logic [2:0]       Bin,
  output logic [LAP_W-1:0] Lap_count,
  output logic             Locked,
  output logic             Step_err,
`ifdef GRAY_DIR_DETECT_EN
  output logic             Dir,
`endif
  output logic             Err_sticky
);

  state_t           state_reg, state_next;
  logic [2:0]       prev_reg, prev_next;
  logic [2:0]       bin_reg, bin_next;
  logic [LAP_W-1:0] lap_reg, lap_next;
  logic             step_err_reg, step_err_next;
  logic             err_sticky_reg, err_sticky_next;
  logic             dir_reg, dir_next;
  logic [2:0]       s_bin;

  gray_to_bin u_gray_to_bin (
    .gray (S),
    .bin  (s_bin)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg      <= UNLOCKED;
      prev_reg       <= 3'b000;
      bin_reg        <= 3'b000;
      lap_reg        <= '0;
      step_err_reg   <= 1'b0;
      err_sticky_reg <= 1'b0;
      dir_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      prev_reg       <= prev_next;
      bin_reg        <= bin_next;
      lap_reg        <= lap_next;
      step_err_reg   <= step_err_next;
      err_sticky_reg <= err_sticky_next;
      dir_reg        <= dir_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    prev_next       = prev_reg;
    bin_next        = bin_reg;
    lap_next        = lap_reg;
    step_err_next   = 1'b0;
    err_sticky_next = err_sticky_reg;
    dir_next        = dir_reg;

    // Clearing takes priority over any sample arriving in the same cycle.
    if (Clr_err) begin
      state_next      = UNLOCKED;
      err_sticky_next = 1'b0;
      lap_next        = '0;
    end else if (S_valid) begin
      unique case (state_reg)
        UNLOCKED: begin
          prev_next  = S;
          bin_next   = s_bin;
          dir_next   = 1'b0;
          state_next = LOCKED;
        end
        LOCKED: begin
          if (S == prev_reg) begin
            state_next = LOCKED;
          end else if (S == next_gray(prev_reg)) begin
            prev_next = S;
            bin_next  = s_bin;
            dir_next  = 1'b0;
            if (prev_reg == 3'b100 && lap_reg != {LAP_W{1'b1}})
              lap_next = lap_reg + LAP_W'(1);
          end
`ifdef GRAY_DIR_DETECT_EN
          else if (S == prev_gray(prev_reg)) begin
            prev_next = S;
            bin_next  = s_bin;
            dir_next  = 1'b1;
            if (prev_reg == 3'b000 && lap_reg != '0)
              lap_next = lap_reg - LAP_W'(1);
          end
`endif
          else begin
            step_err_next   = 1'b1;
            err_sticky_next = 1'b1;
            state_next      = FAULT;
          end
        end
        FAULT: begin
          state_next = FAULT;
        end
        default: begin
          state_next = UNLOCKED;
        end
      endcase
    end
  end

  assign Bin        = bin_reg;
  assign Lap_count  = lap_reg;
  assign Locked     = (state_reg == LOCKED);
  assign Step_err   = step_err_reg;
  assign Err_sticky = err_sticky_reg;
`ifdef GRAY_DIR_DETECT_EN
  assign Dir        = dir_reg;
`else
  logic unused_dir;
  assign unused_dir = dir_reg;
`endif

endmodule

// File: tb/tb_gray_code_monitor.sv
// Self-checking bench for gray_code_monitor: vector table, directed corner sequences
// and randomized stimulus against a sequence-position reference model.
module tb_gray_code_monitor;

  localparam int LAP_W   = 2;
  localparam int LAP_MAX = (1 << LAP_W) - 1;
`ifdef GRAY_DIR_DETECT_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif

  logic             Clk = 1'b0;
  logic             Rst = 1'b1;
  logic [2:0]       S = 3'b000;
  logic             S_valid = 1'b0;
  logic             Clr_err = 1'b0;
  logic [2:0]       Bin;
  logic [LAP_W-1:0] Lap_count;
  logic             Locked;
  logic             Step_err;
  logic             Err_sticky;
`ifdef GRAY_DIR_DETECT_EN
  logic             Dir;
`endif

  gray_code_monitor #(.LAP_W(LAP_W)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .S          (S),
    .S_valid    (S_valid),
    .Clr_err    (Clr_err),
    .Bin        (Bin),
    .Lap_count  (Lap_count),
    .Locked     (Locked),
    .Step_err   (Step_err),
`ifdef GRAY_DIR_DETECT_EN
    .Dir        (Dir),
`endif
    .Err_sticky (Err_sticky)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: position in the 8-step sequence plus mode flags.
  int m_mode;   // 0 unlocked, 1 locked, 2 fault
  int m_pos;
  int m_lap;
  bit m_sticky;
  bit m_step;
  bit m_dir;

  typedef struct {
    logic [2:0] s;
    logic       v;
    logic       clr;
    logic [2:0] bin;
    int         lap;
    logic       locked;
    logic       se;
    logic       st;
  } vec_t;

  vec_t tbl [10];

  function automatic logic [2:0] gray_of(input int i);
    int k;
    k = i % 8;
    return 3'(k ^ (k >> 1));
  endfunction

  function automatic int pos_of(input logic [2:0] g);
    for (int i = 0; i < 8; i++)
      if (gray_of(i) == g) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_lap = 0;
    m_sticky = 1'b0; m_step = 1'b0; m_dir = 1'b0;
  endtask

  task automatic model_update(input logic [2:0] s, input logic v, input logic clr);
    int idx, d;
    m_step = 1'b0;
    if (clr) begin
      m_mode = 0; m_sticky = 1'b0; m_lap = 0;
    end else if (v && m_mode == 0) begin
      m_pos = pos_of(s); m_mode = 1; m_dir = 1'b0;
    end else if (v && m_mode == 1) begin
      idx = pos_of(s);
      d = (idx - m_pos + 8) % 8;
      if (d == 1) begin
        if (m_pos == 7 && m_lap < LAP_MAX) m_lap++;
        m_pos = idx; m_dir = 1'b0;
      end else if (d == 7 && DIR_EN) begin
        if (m_pos == 0 && m_lap > 0) m_lap--;
        m_pos = idx; m_dir = 1'b1;
      end else if (d != 0) begin
        m_step = 1'b1; m_sticky = 1'b1; m_mode = 2;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_bin"}, 32'(Bin), 32'(m_pos));
    check({tag, "_lap"}, 32'(Lap_count), 32'(m_lap));
    check({tag, "_locked"}, 32'(Locked), 32'(m_mode == 1));
    check({tag, "_step_err"}, 32'(Step_err), 32'(m_step));
    check({tag, "_sticky"}, 32'(Err_sticky), 32'(m_sticky));
`ifdef GRAY_DIR_DETECT_EN
    check({tag, "_dir"}, 32'(Dir), 32'(m_dir));
`endif
  endtask

  task automatic apply(input string tag, input logic [2:0] s, input logic v, input logic clr);
    S = s; S_valid = v; Clr_err = clr;
    model_update(s, v, clr);
    @(posedge Clk);
    #1;
    $display("%s: S=%b v=%0b clr=%0b -> Bin=%0d Lap=%0d Lk=%0b Se=%0b St=%0b",
             tag, s, v, clr, Bin, Lap_count, Locked, Step_err, Err_sticky);
    check_model(tag);
  endtask

  task automatic do_reset();
    Rst = 1'b1; S_valid = 1'b0; Clr_err = 1'b0;
    model_reset();
    #2;
    Rst = 1'b0;
  endtask

  initial begin
    bit seen_err;
    tbl[0] = '{3'b000, 1'b1, 1'b0, 3'd0, 0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{3'b001, 1'b1, 1'b0, 3'd1, 0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{3'b001, 1'b1, 1'b0, 3'd1, 0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{3'b110, 1'b1, 1'b0, 3'd1, 0, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{3'b110, 1'b0, 1'b0, 3'd1, 0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{3'b011, 1'b1, 1'b0, 3'd1, 0, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{3'b011, 1'b1, 1'b1, 3'd1, 0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{3'b011, 1'b1, 1'b0, 3'd2, 0, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{3'b010, 1'b0, 1'b0, 3'd2, 0, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{3'b010, 1'b1, 1'b0, 3'd3, 0, 1'b1, 1'b0, 1'b0};

    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    $display("reset: Bin=%0d Lap=%0d Lk=%0b Se=%0b St=%0b", Bin, Lap_count, Locked, Step_err, Err_sticky);
    check_model("reset");
    Rst = 1'b0;

    // Lock, illegal jump, fault, clear colliding with a sample, relock.
    for (int i = 0; i < 10; i++) begin
      apply($sformatf("tbl%0d", i), tbl[i].s, tbl[i].v, tbl[i].clr);
      check($sformatf("tbl%0d_bin", i), 32'(Bin), 32'(tbl[i].bin));
      check($sformatf("tbl%0d_lap", i), 32'(Lap_count), 32'(tbl[i].lap));
      check($sformatf("tbl%0d_locked", i), 32'(Locked), 32'(tbl[i].locked));
      check($sformatf("tbl%0d_step_err", i), 32'(Step_err), 32'(tbl[i].se));
      check($sformatf("tbl%0d_sticky", i), 32'(Err_sticky), 32'(tbl[i].st));
    end

    // Backward step 011 -> 001.
    do_reset();
    apply("bwd_lock", 3'b011, 1'b1, 1'b0);
    apply("bwd_step", 3'b001, 1'b1, 1'b0);
`ifdef GRAY_DIR_DETECT_EN
    check("bwd_bin", 32'(Bin), 32'd1);
    check("bwd_dir", 32'(Dir), 32'd1);
    check("bwd_step_err", 32'(Step_err), 32'd0);
`else
    check("bwd_step_err", 32'(Step_err), 32'd1);
    check("bwd_bin", 32'(Bin), 32'd2);
    check("bwd_locked", 32'(Locked), 32'd0);
`endif
    apply("bwd_after", 3'b001, 1'b0, 1'b0);
    check("bwd_pulse_end", 32'(Step_err), 32'd0);

    // Forward sequence: two wraps give 2, five wraps saturate at 3.
    do_reset();
    seen_err = 1'b0;
    apply("fwd_lock", 3'b000, 1'b1, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      apply($sformatf("fwd%0d", i), gray_of(i), 1'b1, 1'b0);
      seen_err |= Step_err;
      if (i == 16) check("two_wraps_lap", 32'(Lap_count), 32'd2);
    end
    check("sat_lap", 32'(Lap_count), 32'd3);
    check("fwd_no_err", 32'(seen_err), 32'd0);

    // Asynchronous reset between edges, then relock on 111.
    do_reset();
    for (int i = 0; i < 10; i++)
      apply($sformatf("pre_rst%0d", i), gray_of(i), 1'b1, 1'b0);
    #2;
    Rst = 1'b1;
    model_reset();
    #1;
    check("async_bin", 32'(Bin), 32'd0);
    check("async_lap", 32'(Lap_count), 32'd0);
    check("async_locked", 32'(Locked), 32'd0);
    check_model("async");
    #2;
    Rst = 1'b0;
    apply("relock", 3'b111, 1'b1, 1'b0);
    check("relock_bin", 32'(Bin), 32'd5);
    check("relock_locked", 32'(Locked), 32'd1);

    // Randomized traffic biased toward legal steps.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [2:0] s;
      r = $urandom_range(0, 99);
      if (r < 45)      s = gray_of(m_pos + 1);
      else if (r < 60) s = gray_of(m_pos);
      else if (r < 70) s = gray_of(m_pos + 7);
      else             s = 3'($urandom_range(0, 7));
      apply($sformatf("rnd%0d", n), s, 1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 99) < 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
